eeg_pea_disp: RTL and testbench
===============================

# eeg_pea_disp

Parametrised dispatch stage between the activation/weight fetch streams and the PE array. Each column's activation beat is joined with one weight beat per enabled row and written into a per-PE FIFO. Each FIFO feeds one PE over a valid/ready port. The block adds three things: a programmable active-row mask, a broadcast mode in which column 0 drives every column, and synchronous flush. Array idle status is derived from FIFO occupancy and PE idle flags.

## Interface
- PE_ROW, 4, PE rows
- PE_COL, 4, PE columns
- PE_ACT_DW, 8, activation data width
- PE_WEI_DW, 8, weight data width
- PE_ACT_IW, 12, activation info (address) width
- PE_WEI_IW, 3, weight info (index) width
- PE_BUF_NW, 4, per-PE FIFO depth; power of two, ≥2
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- CFG_LOAD  in  1  capture CFG_ROW_EN/CFG_BCAST
- CFG_ROW_EN  in  PE_ROW  active-row mask
- CFG_BCAST  in  1  broadcast column-0 activation to all columns
- CFG_ERR  out  1  sticky: CFG_LOAD seen while not idle
- FLUSH  in  1  synchronous clear of all FIFOs
- ACT_VLD/ACT_RDY/ACT_LST  in/out/in  PE_COL  per-column activation handshake and last flag
- ACT_DAT, ACT_INF  in  PE_COL×PE_ACT_DW, PE_COL×PE_ACT_IW  activation data and info
- WEI_VLD/WEI_RDY/WEI_LST  in/out/in  PE_COL×PE_ROW  per-PE weight handshake and last flag
- WEI_DAT, WEI_INF  in  PE_COL×PE_ROW×PE_WEI_DW, ×PE_WEI_IW  weight data and info
- PE_VLD  out  PE_ROW×PE_COL  FIFO non-empty
- PE_RDY  in  PE_ROW×PE_COL  PE accepts head
- PE_ACT_DAT, PE_ACT_INF, PE_ACT_LST, PE_WEI_DAT, PE_WEI_INF, PE_WEI_LST  out  PE_ROW×PE_COL×field width  FIFO head fields
- PE_IDLE  in  PE_ROW×PE_COL  PE idle flags
- IS_IDLE  out  1  all FIFOs empty and &PE_IDLE

## Operation
- Config registers are row_en and bcast. Reset values: row_en = all ones, bcast = 0.
- CFG_LOAD captures both registers only when IS_IDLE=1. Otherwise CFG_LOAD is ignored and CFG_ERR sets. CFG_ERR clears only on reset.
- Per-row-column term: ok[i][j] = ~row_en[i] | (WEI_VLD[j][i] & ~full[i][j]).
- Column term: col_ok[j] = AND over i of ok[i][j].
- Src(j) is the activation source column: 0 if bcast, else j.
- Per-column mode (bcast=0):
  - ACT_RDY[j] = col_ok[j].
  - fire[j] = ACT_VLD[j] & col_ok[j].
- Broadcast mode (bcast=1):
  - ACT_RDY[0] = AND over j of col_ok[j]; ACT_RDY[j>0] = 0.
  - fire[j] = ACT_VLD[0] & ACT_RDY[0] for all j.
- WEI_RDY[j][i] = row_en[i] & ACT_VLD[src(j)] & ACT_RDY[src(j)].
- Disabled rows: WEI_RDY=0, nothing written, and their FIFOs stay empty.
- On fire[j], every enabled row i pushes {WEI_LST, ACT_LST, WEI_INF, ACT_INF, WEI_DAT, ACT_DAT} into FIFO[i][j]. ACT fields come from src(j); WEI fields come from [j][i].
- FIFO pop on PE_VLD & PE_RDY.
- Push and pop in the same cycle are legal at any occupancy below full. When full, push is blocked by ACT_RDY, so no overflow is possible.
- FLUSH empties all FIFOs next cycle, with pointers zeroed. Pushes and pops in the FLUSH cycle are discarded. ACT_RDY/WEI_RDY are forced 0 during FLUSH.
- Pointers wrap modulo PE_BUF_NW. Full/empty are derived from a count of $clog2(PE_BUF_NW)+1 bits.

## Timing
- The accepted beat appears at PE_VLD the next cycle (1-cycle latency).
- FIFO is first-word fall-through; head fields are valid whenever PE_VLD=1.
- ACT_RDY/WEI_RDY are combinational from WEI_VLD/ACT_VLD and full. Ready may depend on valid; upstream must not make valid depend on ready.
- Reset values: PE_VLD=0, CFG_ERR=0, head fields 0. IS_IDLE equals &PE_IDLE. Ready outputs follow the combinational equations with all FIFOs empty.
- Asserting rst_n low mid-operation discards all FIFO contents asynchronously.
- Throughput: 1 beat/column/cycle when PEs pop every cycle.

## Configuration
- EEG_PEA_DISP_STAT_EN defined: adds output STAT_STALL, PE_COL×16, one counter per column.
  - Counts cycles with ACT_VLD[j] & ~ACT_RDY[j].
  - Saturates at 0xFFFF.
  - Cleared by reset or FLUSH.
- Not defined: the port and counters are absent; all other behaviour is identical.

## Structure
- Shared package eeg_pea_pkg holds:
  - the FIFO entry struct (field order as pushed);
  - localparam entry width = PE_ACT_DW+PE_WEI_DW+PE_ACT_IW+PE_WEI_IW+2.
- Sub-module eeg_pea_disp_fifo: FWFT FIFO with sync clear. It is instantiated PE_ROW×PE_COL times; join logic stays at top level.

## Test plan
- Per-column join: ROW=COL=4, row_en=4'b1111, all valid, PE_RDY=1; column 0 sends 10 beats → each PE[i][0] receives the same 10 ACT values with its own weights, 1-cycle latency, no stalls.
- Backpressure: PE_RDY[2][1]=0 for 6 cycles → ACT_RDY[1] drops after 4 accepts. No FIFO in column 1 exceeds 4 entries. Other columns are unaffected.
- Row mask: load row_en=4'b0101 while idle → WEI_RDY[*][1] and WEI_RDY[*][3] stay 0, and FIFOs in rows 1/3 stay empty. ACT_RDY ignores WEI_VLD of rows 1/3.
- Broadcast: bcast=1; ACT_DAT[0]=0x5A, ACT_VLD[1..3]=1 → all 16 PEs see ACT 0x5A; ACT_RDY[1..3]=0.
- Illegal load and flush: CFG_LOAD with one FIFO non-empty → config unchanged, CFG_ERR=1. FLUSH → all PE_VLD=0 next cycle, and IS_IDLE=1 once PE_IDLE is all ones.
- With EEG_PEA_DISP_STAT_EN: hold ACT_VLD[2]=1 with WEI_VLD[2][0]=0 for 70000 cycles → STAT_STALL[2]=0xFFFF.

Source files
------------

// File: rtl/eeg_pea_pkg.sv
// Shared types for the PE-array dispatch stage: default field widths and the FIFO entry layout.
package eeg_pea_pkg;

  localparam int unsigned PEA_ACT_DW = 8;
  localparam int unsigned PEA_WEI_DW = 8;
  localparam int unsigned PEA_ACT_IW = 12;
  localparam int unsigned PEA_WEI_IW = 3;

  function automatic int unsigned pea_ent_width(input int unsigned act_dw,
                                                input int unsigned wei_dw,
                                                input int unsigned act_iw,
                                                input int unsigned wei_iw);
    return act_dw + wei_dw + act_iw + wei_iw + 2;
  endfunction

  localparam int unsigned PEA_ENT_W = pea_ent_width(PEA_ACT_DW, PEA_WEI_DW, PEA_ACT_IW, PEA_WEI_IW);

  // Field order matches the packed word pushed into each per-PE FIFO (MSB first).
  typedef struct packed {
    logic                  wei_lst;
    logic                  act_lst;
    logic [PEA_WEI_IW-1:0] wei_inf;
    logic [PEA_ACT_IW-1:0] act_inf;
    logic [PEA_WEI_DW-1:0] wei_dat;
    logic [PEA_ACT_DW-1:0] act_dat;
  } pea_ent_t;

endpackage

// File: rtl/eeg_pea_disp_if.sv
// Activation/weight fetch streams and PE-side FIFO ports of the dispatch stage.
interface eeg_pea_disp_if #(
  parameter int unsigned PE_ROW    = 4,
  parameter int unsigned PE_COL    = 4,
  parameter int unsigned PE_ACT_DW = 8,
  parameter int unsigned PE_WEI_DW = 8,
  parameter int unsigned PE_ACT_IW = 12,
  parameter int unsigned PE_WEI_IW = 3
);
  logic [PE_COL-1:0]                ACT_VLD;
  logic [PE_COL-1:0]                ACT_RDY;
  logic [PE_COL-1:0]                ACT_LST;
  logic [PE_COL-1:0][PE_ACT_DW-1:0] ACT_DAT;
  logic [PE_COL-1:0][PE_ACT_IW-1:0] ACT_INF;

  logic [PE_COL-1:0][PE_ROW-1:0]                WEI_VLD;
  logic [PE_COL-1:0][PE_ROW-1:0]                WEI_RDY;
  logic [PE_COL-1:0][PE_ROW-1:0]                WEI_LST;
  logic [PE_COL-1:0][PE_ROW-1:0][PE_WEI_DW-1:0] WEI_DAT;
  logic [PE_COL-1:0][PE_ROW-1:0][PE_WEI_IW-1:0] WEI_INF;

  logic [PE_ROW-1:0][PE_COL-1:0]                PE_VLD;
  logic [PE_ROW-1:0][PE_COL-1:0]                PE_RDY;
  logic [PE_ROW-1:0][PE_COL-1:0][PE_ACT_DW-1:0] PE_ACT_DAT;
  logic [PE_ROW-1:0][PE_COL-1:0][PE_ACT_IW-1:0] PE_ACT_INF;
  logic [PE_ROW-1:0][PE_COL-1:0]                PE_ACT_LST;
  logic [PE_ROW-1:0][PE_COL-1:0][PE_WEI_DW-1:0] PE_WEI_DAT;
  logic [PE_ROW-1:0][PE_COL-1:0][PE_WEI_IW-1:0] PE_WEI_INF;
  logic [PE_ROW-1:0][PE_COL-1:0]                PE_WEI_LST;

  modport master (
    output ACT_VLD, ACT_LST, ACT_DAT, ACT_INF,
    output WEI_VLD, WEI_LST, WEI_DAT, WEI_INF,
    output PE_RDY,
    input  ACT_RDY, WEI_RDY,
    input  PE_VLD, PE_ACT_DAT, PE_ACT_INF, PE_ACT_LST, PE_WEI_DAT, PE_WEI_INF, PE_WEI_LST
  );

  modport slave (
    input  ACT_VLD, ACT_LST, ACT_DAT, ACT_INF,
    input  WEI_VLD, WEI_LST, WEI_DAT, WEI_INF,
    input  PE_RDY,
    output ACT_RDY, WEI_RDY,
    output PE_VLD, PE_ACT_DAT, PE_ACT_INF, PE_ACT_LST, PE_WEI_DAT, PE_WEI_INF, PE_WEI_LST
  );
endinterface

// File: rtl/eeg_pea_disp_fifo.sv
// First-word fall-through FIFO with synchronous clear; head reads zero while empty.
module eeg_pea_disp_fifo #(
  parameter int unsigned DW    = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic          vld_o,
  output logic          full_o,
  output logic [DW-1:0] dout_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign vld_o   = (cnt_q != '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & vld_o & ~clr_i;
  assign dout_o  = vld_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/eeg_pea_disp.sv
// PE-array dispatch: joins activation and weight beats into per-PE FIFOs with row mask and broadcast.
// Optional stall counters per column when EEG_PEA_DISP_STAT_EN is defined.
module eeg_pea_disp
  import eeg_pea_pkg::*;
#(
  parameter int unsigned PE_ROW    = 4,
  parameter int unsigned PE_COL    = 4,
  parameter int unsigned PE_ACT_DW = PEA_ACT_DW,
  parameter int unsigned PE_WEI_DW = PEA_WEI_DW,
  parameter int unsigned PE_ACT_IW = PEA_ACT_IW,
  parameter int unsigned PE_WEI_IW = PEA_WEI_IW,
  parameter int unsigned PE_BUF_NW = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           CFG_LOAD,
  input  logic [PE_ROW-1:0]              CFG_ROW_EN,
  input  logic                           CFG_BCAST,
  output logic                           CFG_ERR,
  input  logic                           FLUSH,
  input  logic [PE_ROW-1:0][PE_COL-1:0]  PE_IDLE,
  output logic                           IS_IDLE,
`ifdef EEG_PEA_DISP_STAT_EN
  output logic [PE_COL-1:0][15:0]        STAT_STALL,
`endif
  eeg_pea_disp_if.slave                  bus
);
  localparam int unsigned ENT_W = pea_ent_width(PE_ACT_DW, PE_WEI_DW, PE_ACT_IW, PE_WEI_IW);

  logic [PE_ROW-1:0] row_en_q, row_en_d;
  logic              bcast_q, bcast_d;
  logic              cfg_err_q, cfg_err_d;

  logic [PE_ROW-1:0][PE_COL-1:0] vld_w, full_w;
  logic [PE_COL-1:0]             col_ok, act_rdy, fire;
  logic [PE_COL-1:0][PE_ROW-1:0] wei_rdy;

  assign IS_IDLE = ~(|vld_w) & (&PE_IDLE);
  assign CFG_ERR = cfg_err_q;

  always_comb begin
    row_en_d  = row_en_q;
    bcast_d   = bcast_q;
    cfg_err_d = cfg_err_q;
    if (CFG_LOAD) begin
      if (IS_IDLE) begin
        row_en_d = CFG_ROW_EN;
        bcast_d  = CFG_BCAST;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_en_q  <= '1;
      bcast_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      row_en_q  <= row_en_d;
      bcast_q   <= bcast_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // A column is ready only when every enabled row has a weight and FIFO room.
  always_comb begin
    col_ok  = '1;
    act_rdy = '0;
    fire    = '0;
    wei_rdy = '0;
    for (int unsigned j = 0; j < PE_COL; j++)
      for (int unsigned i = 0; i < PE_ROW; i++)
        if (row_en_q[i] && !(bus.WEI_VLD[j][i] && !full_w[i][j])) col_ok[j] = 1'b0;
    if (!FLUSH) begin
      if (bcast_q) act_rdy[0] = &col_ok;
      else         act_rdy    = col_ok;
    end
    for (int unsigned j = 0; j < PE_COL; j++) begin
      fire[j] = bcast_q ? (bus.ACT_VLD[0] & act_rdy[0]) : (bus.ACT_VLD[j] & act_rdy[j]);
      for (int unsigned i = 0; i < PE_ROW; i++)
        wei_rdy[j][i] = row_en_q[i] & fire[j];
    end
  end

  assign bus.ACT_RDY = act_rdy;
  assign bus.WEI_RDY = wei_rdy;
  assign bus.PE_VLD  = vld_w;

  for (genvar j = 0; j < PE_COL; j++) begin : g_col
    logic [PE_ACT_DW-1:0] a_dat;
    logic [PE_ACT_IW-1:0] a_inf;
    logic                 a_lst;

    assign a_dat = bcast_q ? bus.ACT_DAT[0] : bus.ACT_DAT[j];
    assign a_inf = bcast_q ? bus.ACT_INF[0] : bus.ACT_INF[j];
    assign a_lst = bcast_q ? bus.ACT_LST[0] : bus.ACT_LST[j];

    for (genvar i = 0; i < PE_ROW; i++) begin : g_row
      logic [ENT_W-1:0] din, head;

      assign din = {bus.WEI_LST[j][i], a_lst, bus.WEI_INF[j][i], a_inf, bus.WEI_DAT[j][i], a_dat};

      eeg_pea_disp_fifo #(
        .DW    (ENT_W),
        .DEPTH (PE_BUF_NW)
      ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (FLUSH),
        .push_i (fire[j] & row_en_q[i]),
        .din_i  (din),
        .pop_i  (bus.PE_RDY[i][j]),
        .vld_o  (vld_w[i][j]),
        .full_o (full_w[i][j]),
        .dout_o (head)
      );

      assign {bus.PE_WEI_LST[i][j], bus.PE_ACT_LST[i][j], bus.PE_WEI_INF[i][j],
              bus.PE_ACT_INF[i][j], bus.PE_WEI_DAT[i][j], bus.PE_ACT_DAT[i][j]} = head;
    end
  end

`ifdef EEG_PEA_DISP_STAT_EN
  logic [PE_COL-1:0][15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int unsigned j = 0; j < PE_COL; j++) begin
      if (FLUSH)
        stall_d[j] = '0;
      else if (bus.ACT_VLD[j] && !act_rdy[j] && stall_q[j] != '1)
        stall_d[j] = stall_q[j] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign STAT_STALL = stall_q;
`endif
endmodule

// File: tb/tb_eeg_pea_disp.sv
// Scoreboard bench for eeg_pea_disp: per-PE expected queues filled on accepted beats, drained on PE pops.
module tb_eeg_pea_disp;
  import eeg_pea_pkg::*;

  localparam int unsigned R = 4;
  localparam int unsigned C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic CFG_LOAD = 1'b0;
  logic [R-1:0] CFG_ROW_EN = '1;
  logic CFG_BCAST = 1'b0;
  logic CFG_ERR;
  logic FLUSH = 1'b0;
  logic [R-1:0][C-1:0] PE_IDLE = '1;
  logic IS_IDLE;
`ifdef EEG_PEA_DISP_STAT_EN
  logic [C-1:0][15:0] STAT_STALL;
`endif

  always #5 clk = ~clk;

  eeg_pea_disp_if #(.PE_ROW(R), .PE_COL(C), .PE_ACT_DW(8), .PE_WEI_DW(8),
                    .PE_ACT_IW(12), .PE_WEI_IW(3)) bus ();

  eeg_pea_disp #(.PE_ROW(R), .PE_COL(C), .PE_ACT_DW(8), .PE_WEI_DW(8),
                 .PE_ACT_IW(12), .PE_WEI_IW(3), .PE_BUF_NW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CFG_LOAD   (CFG_LOAD),
    .CFG_ROW_EN (CFG_ROW_EN),
    .CFG_BCAST  (CFG_BCAST),
    .CFG_ERR    (CFG_ERR),
    .FLUSH      (FLUSH),
    .PE_IDLE    (PE_IDLE),
    .IS_IDLE    (IS_IDLE),
`ifdef EEG_PEA_DISP_STAT_EN
    .STAT_STALL (STAT_STALL),
`endif
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [R-1:0] row_en_m = '1;
  logic bcast_m = 1'b0;
  pea_ent_t sb_q [R*C][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [R-1:0][C-1:0] vld_exp;
  logic [C-1:0][R-1:0] wrdy_exp;
  logic [C-1:0] fire_m;
  pea_ent_t e_exp, e_got;
  int unsigned src;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) vld_exp[i][j] = (sb_q[i*C+j].size() != 0);
      chk("pe_vld", 64'(bus.PE_VLD), 64'(vld_exp));
      for (int j = 0; j < C; j++) begin
        fire_m[j] = bcast_m ? (bus.ACT_VLD[0] & bus.ACT_RDY[0]) : (bus.ACT_VLD[j] & bus.ACT_RDY[j]);
        for (int i = 0; i < R; i++) wrdy_exp[j][i] = row_en_m[i] & fire_m[j];
      end
      chk("wei_rdy", 64'(bus.WEI_RDY), 64'(wrdy_exp));
      if (FLUSH) begin
        for (int k = 0; k < R*C; k++) sb_q[k].delete();
      end else begin
        for (int i = 0; i < R; i++)
          for (int j = 0; j < C; j++)
            if (bus.PE_VLD[i][j] && bus.PE_RDY[i][j]) begin
              e_got = {bus.PE_WEI_LST[i][j], bus.PE_ACT_LST[i][j], bus.PE_WEI_INF[i][j],
                       bus.PE_ACT_INF[i][j], bus.PE_WEI_DAT[i][j], bus.PE_ACT_DAT[i][j]};
              if (sb_q[i*C+j].size() == 0) chk("pe_unexp", 64'(e_got), 64'hDEAD);
              else begin
                e_exp = sb_q[i*C+j].pop_front();
                chk("pe_head", 64'(e_got), 64'(e_exp));
              end
            end
        for (int j = 0; j < C; j++)
          if (fire_m[j]) begin
            src = bcast_m ? 0 : j;
            for (int i = 0; i < R; i++)
              if (row_en_m[i]) begin
                e_exp.wei_lst = bus.WEI_LST[j][i];
                e_exp.act_lst = bus.ACT_LST[src];
                e_exp.wei_inf = bus.WEI_INF[j][i];
                e_exp.act_inf = bus.ACT_INF[src];
                e_exp.wei_dat = bus.WEI_DAT[j][i];
                e_exp.act_dat = bus.ACT_DAT[src];
                sb_q[i*C+j].push_back(e_exp);
              end
          end
      end
    end
  end

  task automatic rand_data();
    for (int j = 0; j < C; j++) begin
      bus.ACT_DAT[j] = 8'($urandom);
      bus.ACT_INF[j] = 12'($urandom);
      bus.ACT_LST[j] = 1'($urandom);
      for (int i = 0; i < R; i++) begin
        bus.WEI_DAT[j][i] = 8'($urandom);
        bus.WEI_INF[j][i] = 3'($urandom);
        bus.WEI_LST[j][i] = 1'($urandom);
      end
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_load(input logic [R-1:0] ren, input logic bc, input logic legal);
    CFG_ROW_EN = ren;
    CFG_BCAST  = bc;
    CFG_LOAD   = 1'b1;
    next_cyc();
    CFG_LOAD = 1'b0;
    if (legal) begin
      row_en_m = ren;
      bcast_m  = bc;
    end
  endtask

  task automatic drain();
    int k;
    bus.ACT_VLD = '0;
    bus.PE_RDY  = '1;
    k = 0;
    while (bus.PE_VLD != '0 && k < 20) begin
      next_cyc();
      k++;
    end
    next_cyc();
    chk("drain", 64'(bus.PE_VLD), 64'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ACT_VLD = '0;
    bus.WEI_VLD = '1;
    bus.PE_RDY  = '1;
    rand_data();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_pe_vld", 64'(bus.PE_VLD), 64'h0);
    chk("rst_cfg_err", 64'(CFG_ERR), 64'h0);
    chk("rst_is_idle", 64'(IS_IDLE), 64'h1);
    chk("rst_head_act", 64'(bus.PE_ACT_DAT), 64'h0);
    chk("rst_head_wei", 64'(bus.PE_WEI_DAT), 64'h0);
    chk("rst_act_rdy", 64'(bus.ACT_RDY), 64'hF);
    chk("rst_wei_rdy", 64'(bus.WEI_RDY), 64'h0);
    PE_IDLE[1][2] = 1'b0;
    #1 chk("idle_pe_busy", 64'(IS_IDLE), 64'h0);
    PE_IDLE = '1;
    next_cyc();
    mon_en = 1'b1;

    // column 0 join, 10 beats, no stalls
    for (int k = 0; k < 10; k++) begin
      rand_data();
      bus.ACT_VLD = 4'b0001;
      @(negedge clk);
      chk("join_rdy0", 64'(bus.ACT_RDY[0]), 64'h1);
      next_cyc();
    end
    drain();

    // backpressure on PE[2][1]
    bus.PE_RDY[2][1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      bus.ACT_VLD = '1;
      @(negedge clk);
      chk("bp_rdy1", 64'(bus.ACT_RDY[1]), 64'(k < 4));
      chk("bp_rdy_oth", 64'({bus.ACT_RDY[3], bus.ACT_RDY[2], bus.ACT_RDY[0]}), 64'h7);
      next_cyc();
    end
    drain();

    // row mask 0101
    cfg_load(4'b0101, 1'b0, 1'b1);
    bus.WEI_VLD = {C{4'b0101}};
    for (int k = 0; k < 5; k++) begin
      rand_data();
      bus.ACT_VLD = '1;
      if (k == 3) bus.WEI_VLD[2][0] = 1'b0;
      else        bus.WEI_VLD[2][0] = 1'b1;
      @(negedge clk);
      chk("mask_act_rdy", 64'(bus.ACT_RDY), (k == 3) ? 64'hB : 64'hF);
      next_cyc();
    end
    drain();

    // broadcast column 0
    bus.WEI_VLD = '1;
    cfg_load(4'b1111, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rand_data();
      bus.ACT_DAT[0] = 8'h5A;
      bus.ACT_VLD = '1;
      @(negedge clk);
      chk("bcast_act_rdy", 64'(bus.ACT_RDY), 64'h1);
      next_cyc();
    end
    drain();
    cfg_load(4'b1111, 1'b0, 1'b1);

    // illegal load while busy, then flush
    bus.PE_RDY = '0;
    rand_data();
    bus.ACT_VLD = 4'b0001;
    next_cyc();
    bus.ACT_VLD = '0;
    chk("busy_is_idle", 64'(IS_IDLE), 64'h0);
    cfg_load(4'b0011, 1'b1, 1'b0);
    bus.WEI_VLD = {C{4'b0011}};
    @(negedge clk);
    chk("ill_cfg_err", 64'(CFG_ERR), 64'h1);
    chk("ill_cfg_kept", 64'(bus.ACT_RDY), 64'h0);
    next_cyc();
    bus.WEI_VLD = '1;
    bus.ACT_VLD = '1;
    bus.PE_RDY  = '1;
    FLUSH = 1'b1;
    @(negedge clk);
    chk("flush_act_rdy", 64'(bus.ACT_RDY), 64'h0);
    next_cyc();
    FLUSH = 1'b0;
    bus.ACT_VLD = '0;
    PE_IDLE = '0;
    @(negedge clk);
    chk("flush_pe_vld", 64'(bus.PE_VLD), 64'h0);
    chk("flush_idle_busy", 64'(IS_IDLE), 64'h0);
    PE_IDLE = '1;
    #1 chk("flush_idle", 64'(IS_IDLE), 64'h1);
    next_cyc();
    cfg_load(4'b1111, 1'b0, 1'b1);
    chk("cfg_err_sticky", 64'(CFG_ERR), 64'h1);

`ifdef EEG_PEA_DISP_STAT_EN
    FLUSH = 1'b1;
    next_cyc();
    FLUSH = 1'b0;
    bus.ACT_VLD = 4'b0100;
    bus.WEI_VLD = '1;
    bus.WEI_VLD[2][0] = 1'b0;
    repeat (10) next_cyc();
    chk("stat_10", 64'(STAT_STALL[2]), 64'd10);
    repeat (69990) next_cyc();
    chk("stat_sat", 64'(STAT_STALL[2]), 64'hFFFF);
    chk("stat_col1", 64'(STAT_STALL[1]), 64'h0);
    bus.ACT_VLD = '0;
    bus.WEI_VLD = '1;
    next_cyc();
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
